phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Generates the 4-bit traffic-phase code and the green-blink bit that the semaphore decoder consumes, i.e. the ciclo_esp32 / dest_esp32 pair.
- Runs the fixed 4-approach cycle locally: green, blinking green, then amber per approach, with a flashing-amber fallback.
- Replaces the ESP32 as code source when local control is selected. Its outputs drive the same decoder inputs through the existing top-level select path.

Parameters:
- TICK_DIV, 27_000_000: clk cycles per 1 s timing tick; the bench overrides it to 4.
- BLINK_S, 3: final seconds of green during which dest is asserted.
- AMBER_S, 3: amber duration in ticks, minimum 1.
- MIN_GREEN, BLINK_S+1: floor applied to the green_s input.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable; 0 requests flashing mode
- flash_req  in  1  error/night request for flashing amber
- green_s  in  8  green duration in ticks, sampled at each green entry
- ciclo  out  4  phase code to decoder
- dest  out  1  green-blink enable to decoder
- phase_start  out  1  one-cycle pulse on every phase change
- sec_tick  out  1  one-cycle timing tick, for observation

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FLASH, idx=0, remaining=0, divider=0.
  - ciclo=4'b0000, dest=0, phase_start=0, sec_tick=0.
  - Reset mid-phase aborts the phase immediately; no amber completion.
- Tick:
  - Divider counts 0..TICK_DIV-1.
  - sec_tick is registered and high for exactly one cycle when divider wraps.
  - First tick comes TICK_DIV cycles after rst deasserts.
- Timing: the FSM acts only on edges where sec_tick=1. All outputs are registered and reflect the new state after that edge.
- Codes: GREEN(idx) drives ciclo=2*idx+1; AMBER(idx) drives ciclo=2*idx+2; FLASH drives ciclo=0.
  - Approach 0 green=1, amber=2; approach 3 green=7, amber=8.
  - Codes 9..15 are never emitted.
- FLASH:
  - dest=0.
  - On a tick with en=1 and flash_req=0, go to GREEN with idx=0.
- GREEN entry: remaining = max(green_s, MIN_GREEN), computed as 8-bit unsigned.
- GREEN:
  - dest=1 when remaining<=BLINK_S, else dest=0.
  - On each tick, remaining decrements.
  - On a tick with remaining==1, go to AMBER(idx) with remaining=AMBER_S.
  - Safety: if flash_req=1 or en=0 on any tick, go to AMBER(idx) at once. Green never goes straight to FLASH.
- AMBER:
  - dest=0 always. Amber with dest=1 is an illegal decoder input.
  - On a tick with remaining==1: if flash_req=1 or en=0, go to FLASH. Otherwise go to GREEN with idx+1 mod 4 (idx 3 wraps to 0).
  - A flash request during amber lets the amber finish before FLASH.
- phase_start: high for one cycle, coincident with the first cycle of the new ciclo value. It is not asserted out of reset.
- Simultaneous flash_req and remaining==1 on a green tick: go to AMBER (same result either way).

Decomposition:
- Package phase_pkg:
  - state enum {S_FLASH, S_GREEN, S_AMBER}.
  - CODE_FLASH=4'd0 and the function for code = f(state, idx).
  - NUM_APPROACHES=4.
- Sub-module tick_gen(clk, rst, sec_tick) with parameter TICK_DIV. It is the synchronous-reset successor to gene_1hz.
- The FSM and the remaining/idx counters stay in phase_sequencer.

Test Plan (TICK_DIV=4, BLINK_S=2, AMBER_S=3, MIN_GREEN=3):
1. Hold rst for 10 cycles with en=1 → ciclo=0, dest=0, phase_start=0 throughout. After release, the first sec_tick arrives 4 cycles later.
2. en=1, flash_req=0, green_s=5 → first tick gives ciclo=1, dest=0, phase_start pulse. After the 3rd further tick dest=1. After the 5th, ciclo=2, dest=0. Three ticks later, ciclo=3.
3. Free-run 40 ticks → code sequence 1,2,3,…,8,1. One full cycle is 32 ticks. Exactly 8 phase_start pulses per cycle. ciclo never exceeds 8.
4. Assert flash_req in green with remaining=4 → next tick gives ciclo=amber code. Three ticks later ciclo=0. Deassert flash_req → next tick gives ciclo=1.
5. green_s=1 → green lasts 3 ticks with dest=1 on the last 2. green_s=0 → same result.
6. Pulse rst for one cycle during AMBER(idx=2) → next edge gives ciclo=0, dest=0, divider restarted. The sequence resumes at ciclo=1.

Source files
------------

// File: rtl/phase_pkg.sv
// Shared types and the phase-code mapping for the local traffic-phase sequencer.
package phase_pkg;

  typedef enum logic [1:0] {
    S_FLASH,
    S_GREEN,
    S_AMBER
  } state_e;

  // Approach index; two bits so that idx+1 wraps 3 -> 0 on its own.
  typedef logic [1:0] idx_t;

  localparam int unsigned NUM_APPROACHES = 4;
  localparam logic [3:0]  CODE_FLASH     = 4'd0;

  // Decoder code: green = 2*idx+1, amber = 2*idx+2, flashing amber = 0.
  function automatic logic [3:0] phase_code(state_e s, idx_t idx);
    logic [3:0] base;
    base = {1'b0, idx, 1'b0};
    case (s)
      S_GREEN: phase_code = base + 4'd1;
      S_AMBER: phase_code = base + 4'd2;
      default: phase_code = CODE_FLASH;
    endcase
  endfunction

endpackage

// File: rtl/phase_sequencer_tick.sv
// One-second timing tick: divider counts 0..TICK_DIV-1, tick is registered
// and high for the single cycle following the wrap.
module tick_gen #(
  parameter int unsigned TICK_DIV = 27_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick
);

  localparam int unsigned        DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // Free-running divider; the tick lands TICK_DIV cycles after reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DIV_LAST);
      div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign sec_tick = tick_q;

endmodule

// File: rtl/phase_sequencer.sv
// Local replacement for the ESP32 phase source: walks the four approaches
// through green, blinking green and amber, falling back to flashing amber.
//
// state   | meaning
// S_FLASH | flashing amber, ciclo=0; leaves on a tick with en=1, flash_req=0
// S_GREEN | green of approach idx; dest=1 in the last BLINK_S ticks
// S_AMBER | amber of approach idx; always runs to completion
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 27_000_000,
  parameter int unsigned BLINK_S   = 3,
  parameter int unsigned AMBER_S   = 3,
  parameter int unsigned MIN_GREEN = BLINK_S + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       flash_req,
  input  logic [7:0] green_s,
  output logic [3:0] ciclo,
  output logic       dest,
  output logic       phase_start,
  output logic       sec_tick
);

  localparam logic [7:0] BLINK_LIM = 8'(BLINK_S);
  localparam logic [7:0] AMBER_LD  = 8'(AMBER_S);
  localparam logic [7:0] GREEN_MIN = 8'(MIN_GREEN);

  logic       tick;
  state_e     state_q;
  idx_t       idx_q;
  logic [7:0] rem_q;
  logic [3:0] ciclo_q;
  logic       dest_q;
  logic       phase_start_q;

  logic       stop_d;
  logic [7:0] green_load_d;
  logic [7:0] rem_dec_d;
  idx_t       idx_next_d;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .sec_tick (tick)
  );

  assign stop_d       = flash_req | ~en;
  assign green_load_d = (green_s > GREEN_MIN) ? green_s : GREEN_MIN;
  assign rem_dec_d    = rem_q - 8'd1;
  assign idx_next_d   = idx_q + 2'd1;

  // Phase FSM: advances only on tick edges; outputs registered with the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FLASH;
      idx_q         <= '0;
      rem_q         <= '0;
      ciclo_q       <= CODE_FLASH;
      dest_q        <= 1'b0;
      phase_start_q <= 1'b0;
    end else begin
      phase_start_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_FLASH: begin
            if (!stop_d) begin
              state_q       <= S_GREEN;
              idx_q         <= '0;
              rem_q         <= green_load_d;
              ciclo_q       <= phase_code(S_GREEN, 2'd0);
              dest_q        <= (green_load_d <= BLINK_LIM);
              phase_start_q <= 1'b1;
            end
          end
          S_GREEN: begin
            // A stop request never skips amber; it just cuts the green short.
            if (stop_d || rem_q == 8'd1) begin
              state_q       <= S_AMBER;
              rem_q         <= AMBER_LD;
              ciclo_q       <= phase_code(S_AMBER, idx_q);
              dest_q        <= 1'b0;
              phase_start_q <= 1'b1;
            end else begin
              rem_q  <= rem_dec_d;
              dest_q <= (rem_dec_d <= BLINK_LIM);
            end
          end
          S_AMBER: begin
            if (rem_q == 8'd1) begin
              phase_start_q <= 1'b1;
              if (stop_d) begin
                state_q <= S_FLASH;
                ciclo_q <= CODE_FLASH;
                dest_q  <= 1'b0;
              end else begin
                state_q <= S_GREEN;
                idx_q   <= idx_next_d;
                rem_q   <= green_load_d;
                ciclo_q <= phase_code(S_GREEN, idx_next_d);
                dest_q  <= (green_load_d <= BLINK_LIM);
              end
            end else begin
              rem_q  <= rem_dec_d;
              dest_q <= 1'b0;
            end
          end
          default: begin
            state_q <= S_FLASH;
            ciclo_q <= CODE_FLASH;
            dest_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ciclo       = ciclo_q;
  assign dest        = dest_q;
  assign phase_start = phase_start_q;
  assign sec_tick    = tick;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: directed per-tick vector table, free-run cycle
// checks, randomized inputs against a code-level reference model, and a
// mid-amber reset.
module tb_phase_sequencer;

  localparam int TICK_DIV  = 4;
  localparam int BLINK_S   = 2;
  localparam int AMBER_S   = 3;
  localparam int MIN_GREEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       flash_req;
  logic [7:0] green_s;
  logic [3:0] ciclo;
  logic       dest;
  logic       phase_start;
  logic       sec_tick;

  int n_err = 0;
  int n_chk = 0;

  // Reference model: phase is the decoder code itself (0 flash, odd green, even amber).
  int m_code;
  int m_rem;
  int m_dest;
  int m_ps;

  typedef struct {
    int e;
    int f;
    int g;
    int c;
    int d;
    int p;
  } vec_t;

  vec_t tv[$];

  always #5 clk = ~clk;

  phase_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .BLINK_S   (BLINK_S),
    .AMBER_S   (AMBER_S),
    .MIN_GREEN (MIN_GREEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .flash_req   (flash_req),
    .green_s     (green_s),
    .ciclo       (ciclo),
    .dest        (dest),
    .phase_start (phase_start),
    .sec_tick    (sec_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int e, input int f, input int g, input int c, input int d, input int p);
    vec_t v;
    v.e = e; v.f = f; v.g = g; v.c = c; v.d = d; v.p = p;
    tv.push_back(v);
  endtask

  task automatic model_reset();
    m_code = 0;
    m_rem  = 0;
    m_dest = 0;
    m_ps   = 0;
  endtask

  task automatic model_tick(input int e, input int f, input int g);
    int  old;
    int  ld;
    bit  stop;
    old  = m_code;
    ld   = (g > MIN_GREEN) ? g : MIN_GREEN;
    stop = (f != 0) || (e == 0);
    if (m_code == 0) begin
      if (!stop) begin
        m_code = 1;
        m_rem  = ld;
      end
    end else if (m_code % 2 == 1) begin
      if (stop || m_rem == 1) begin
        m_code = m_code + 1;
        m_rem  = AMBER_S;
      end else begin
        m_rem = m_rem - 1;
      end
    end else begin
      if (m_rem == 1) begin
        if (stop) m_code = 0;
        else begin
          m_code = (m_code == 8) ? 1 : m_code + 1;
          m_rem  = ld;
        end
      end else begin
        m_rem = m_rem - 1;
      end
    end
    m_dest = ((m_code % 2 == 1) && (m_rem <= BLINK_S)) ? 1 : 0;
    m_ps   = (m_code != old) ? 1 : 0;
  endtask

  // Waits (bounded) for the next sec_tick, checking nothing moves in between.
  task automatic wait_tick(input string name, input int exp_gap, input int exp_code);
    int n;
    int quiet;
    n = 0;
    quiet = 1;
    while (sec_tick !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
      if (sec_tick !== 1'b1 && (phase_start !== 1'b0 || int'(ciclo) != exp_code)) quiet = 0;
    end
    chk({name, "_gap"}, n, exp_gap);
    chk({name, "_quiet"}, quiet, 1);
  endtask

  // Called at a negedge where sec_tick=1: the next posedge is an FSM action edge.
  task automatic do_tick(input int e, input int f, input int g,
                         output int c, output int d, output int p);
    en        = (e != 0);
    flash_req = (f != 0);
    green_s   = 8'(g);
    @(negedge clk);
    c = int'(ciclo);
    d = int'(dest);
    p = int'(phase_start);
    chk("tick_width", int'(sec_tick), 0);
    model_tick(e, f, g);
    wait_tick("tick", 3, c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, p;
    int ps_cnt, maxc, seen, steps;

    rst       = 1'b1;
    en        = 1'b1;
    flash_req = 1'b0;
    green_s   = 8'd5;
    model_reset();

    // directed per-tick vectors {en, flash_req, green_s, ciclo, dest, phase_start}
    add(1,0,5, 1,0,1); add(1,0,5, 1,0,0); add(1,0,5, 1,0,0); add(1,0,5, 1,1,0);
    add(1,0,5, 1,1,0); add(1,0,5, 2,0,1); add(1,0,5, 2,0,0); add(1,0,5, 2,0,0);
    add(1,0,5, 3,0,1); add(1,0,5, 3,0,0);
    add(1,1,5, 4,0,1); add(1,1,5, 4,0,0); add(1,1,5, 4,0,0); add(1,1,5, 0,0,1);
    add(1,1,5, 0,0,0);
    add(1,0,1, 1,0,1); add(1,0,1, 1,1,0); add(1,0,1, 1,1,0); add(1,0,1, 2,0,1);
    add(1,0,1, 2,0,0); add(1,0,1, 2,0,0);
    add(1,0,0, 3,0,1); add(1,0,0, 3,1,0); add(1,0,0, 3,1,0); add(1,0,0, 4,0,1);
    add(1,0,0, 4,0,0); add(1,0,0, 4,0,0);
    add(1,0,200, 5,0,1); add(0,0,200, 6,0,1); add(0,0,200, 6,0,0); add(0,0,200, 6,0,0);
    add(0,0,200, 0,0,1); add(0,0,5, 0,0,0); add(1,1,5, 0,0,0);
    add(1,0,3, 1,0,1); add(1,0,3, 1,1,0); add(1,0,3, 1,1,0); add(1,1,3, 2,0,1);
    add(1,0,3, 2,0,0); add(1,0,3, 2,0,0); add(1,0,4, 3,0,1);

    // reset held with en=1
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ciclo", int'(ciclo), 0);
      chk("rst_dest", int'(dest), 0);
      chk("rst_phase_start", int'(phase_start), 0);
      chk("rst_sec_tick", int'(sec_tick), 0);
    end
    rst = 1'b0;
    wait_tick("first_tick", 4, 0);

    for (int i = 0; i < tv.size(); i++) begin
      do_tick(tv[i].e, tv[i].f, tv[i].g, c, d, p);
      chk($sformatf("vec%0d_ciclo", i), c, tv[i].c);
      chk($sformatf("vec%0d_dest", i), d, tv[i].d);
      chk($sformatf("vec%0d_phase_start", i), p, tv[i].p);
    end

    // free run: full 32-tick cycle, 8 phase changes, codes 1..8 only
    ps_cnt = 0;
    maxc   = 0;
    seen   = 0;
    for (int t = 0; t < 40; t++) begin
      do_tick(1, 0, 5, c, d, p);
      chk("run_ciclo", c, m_code);
      chk("run_dest", d, m_dest);
      chk("run_phase_start", p, m_ps);
      if (t < 32) ps_cnt += p;
      if (c > maxc) maxc = c;
      seen = seen | (1 << c);
    end
    chk("cycle_phase_starts", ps_cnt, 8);
    chk("ciclo_max", maxc, 8);
    chk("codes_seen", seen, 32'h1FE);

    // randomized inputs against the model
    for (int t = 0; t < 200; t++) begin
      int e, f, g;
      e = ($urandom_range(0, 9) != 0) ? 1 : 0;
      f = ($urandom_range(0, 7) == 0) ? 1 : 0;
      g = int'($urandom_range(0, 9));
      do_tick(e, f, g, c, d, p);
      chk("rand_ciclo", c, m_code);
      chk("rand_dest", d, m_dest);
      chk("rand_phase_start", p, m_ps);
      chk("rand_amber_no_dest", ((c != 0) && (c % 2 == 0) && (d != 0)) ? 1 : 0, 0);
    end

    // reach AMBER of approach 2, then pulse reset
    steps = 0;
    while (m_code != 6 && steps < 64) begin
      do_tick(1, 0, 3, c, d, p);
      chk("seek_ciclo", c, m_code);
      steps++;
    end
    chk("reach_amber2", int'(ciclo), 6);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ciclo", int'(ciclo), 0);
    chk("midrst_dest", int'(dest), 0);
    chk("midrst_phase_start", int'(phase_start), 0);
    chk("midrst_sec_tick", int'(sec_tick), 0);
    rst = 1'b0;
    model_reset();
    wait_tick("midrst_first_tick", 4, 0);
    do_tick(1, 0, 5, c, d, p);
    chk("resume_ciclo", c, 1);
    chk("resume_dest", d, 0);
    chk("resume_phase_start", p, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
